// File: rtl/mux_pipe.sv
// N-to-1 channel mux with a two-entry skid buffer on a valid/ready stream.
// in_ready and out_valid are flops, so there is no combinational path from out_ready back upstream.
module mux_pipe #(
    parameter int WIDTH = 32,
    parameter int N = 4,
    localparam int SEL_W = (N > 2) ? $clog2(N) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   data_in,
    input  logic [SEL_W-1:0]     selector,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out,
    output logic                 out_sel_err,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic             acc, drn;
    logic             load_new, load_skid, skid_to_main;
    logic [WIDTH:0]   pick_p0;
    logic [WIDTH-1:0] skid_data_p1;
    logic             skid_err_p1;

    // Returns {err, word}; an out-of-range selector yields a zero word with err set.
    function automatic logic [WIDTH:0] pick(input logic [N*WIDTH-1:0] d,
                                            input logic [SEL_W-1:0] s);
        logic [WIDTH:0] r;
        r = {1'b1, {WIDTH{1'b0}}};
        for (int k = 0; k < N; k++) begin
            if (int'(s) == k) begin
                r = {1'b0, d[k*WIDTH +: WIDTH]};
            end
        end
        return r;
    endfunction

    // Stage p0: channel selection on the incoming word
    assign pick_p0 = pick(data_in, selector);

    assign acc = in_valid & in_ready;
    assign drn = out_valid & out_ready;

    always_comb begin
        state_nx     = state;
        load_new     = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state)
            S_EMPTY: begin
                if (acc) begin
                    state_nx = S_ONE;
                    load_new = 1'b1;
                end
            end
            S_ONE: begin
                if (acc && drn) begin
                    load_new = 1'b1;
                end else if (acc) begin
                    state_nx  = S_FULL;
                    load_skid = 1'b1;
                end else if (drn) begin
                    state_nx = S_EMPTY;
                end
            end
            S_FULL: begin
                // in_ready is low here, so only a drain can happen
                if (drn) begin
                    state_nx     = S_ONE;
                    skid_to_main = 1'b1;
                end
            end
            default: state_nx = S_EMPTY;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            in_ready  <= (state_nx != S_FULL);
            out_valid <= (state_nx != S_EMPTY);
        end
    end

    // Stage p1: skid entry, only meaningful while FULL
    always_ff @(posedge clock) begin
        if (load_skid) begin
            skid_data_p1 <= pick_p0[WIDTH-1:0];
            skid_err_p1  <= pick_p0[WIDTH];
        end
    end

    // Stage p1: main entry drives the output directly
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out         <= '0;
            out_sel_err <= 1'b0;
        end else if (load_new) begin
            out         <= pick_p0[WIDTH-1:0];
            out_sel_err <= pick_p0[WIDTH];
        end else if (skid_to_main) begin
            out         <= skid_data_p1;
            out_sel_err <= skid_err_p1;
        end
    end

endmodule

// File: tb/tb_mux_pipe.sv
// Bench for mux_pipe: directed scenarios then random traffic, checked against
// a FIFO-of-words reference model for an N=4 and an N=3 instance.
module tb_mux_pipe;

    logic         clock = 1'b0;
    logic         reset;
    logic [127:0] data_in;
    logic [1:0]   selector;
    logic         in_valid;
    logic         out_ready;

    logic         in_ready4, out_valid4, err4;
    logic [31:0]  out4;
    logic         in_ready3, out_valid3, err3;
    logic [31:0]  out3;

    int checks = 0;
    int errors = 0;

    logic [32:0] q4[$];
    logic [32:0] q3[$];

    always #5 clock = ~clock;

    mux_pipe #(.WIDTH(32), .N(4)) dut4 (
        .clock(clock), .reset(reset), .data_in(data_in), .selector(selector),
        .in_valid(in_valid), .in_ready(in_ready4), .out(out4),
        .out_sel_err(err4), .out_valid(out_valid4), .out_ready(out_ready)
    );

    mux_pipe #(.WIDTH(32), .N(3)) dut3 (
        .clock(clock), .reset(reset), .data_in(data_in[95:0]), .selector(selector),
        .in_valid(in_valid), .in_ready(in_ready3), .out(out3),
        .out_sel_err(err3), .out_valid(out_valid3), .out_ready(out_ready)
    );

    function automatic logic [32:0] exp_word(input int n, input logic [127:0] d,
                                             input logic [1:0] s);
        if (int'(s) < n) return {1'b0, d[int'(s)*32 +: 32]};
        return {1'b1, 32'h0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_model();
        check("ready4", 64'(in_ready4), 64'(q4.size() < 2));
        check("valid4", 64'(out_valid4), 64'(q4.size() > 0));
        if (q4.size() > 0) check("word4", 64'({err4, out4}), 64'(q4[0]));
        check("ready3", 64'(in_ready3), 64'(q3.size() < 2));
        check("valid3", 64'(out_valid3), 64'(q3.size() > 0));
        if (q3.size() > 0) check("word3", 64'({err3, out3}), 64'(q3[0]));
    endtask

    // One clock: apply the stream rules to the model queues, then compare.
    task automatic cycle();
        bit acc4, drn4, acc3, drn3, stall4, stall3;
        logic [32:0] w4, w3, prev4, prev3;
        acc4 = in_valid && (q4.size() < 2);
        drn4 = out_ready && (q4.size() > 0);
        acc3 = in_valid && (q3.size() < 2);
        drn3 = out_ready && (q3.size() > 0);
        w4 = exp_word(4, data_in, selector);
        w3 = exp_word(3, data_in, selector);
        stall4 = out_valid4 && !out_ready;
        stall3 = out_valid3 && !out_ready;
        prev4 = {err4, out4};
        prev3 = {err3, out3};
        @(posedge clock);
        if (drn4) void'(q4.pop_front());
        if (acc4) q4.push_back(w4);
        if (drn3) void'(q3.pop_front());
        if (acc3) q3.push_back(w3);
        #1;
        check_model();
        if (stall4) check("stable4", 64'({err4, out4}), 64'(prev4));
        if (stall3) check("stable3", 64'({err3, out3}), 64'(prev3));
    endtask

    initial begin
        reset     = 1'b1;
        data_in   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        selector  = 2'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_valid", 64'(out_valid4), 64'(0));
        check("rst_ready", 64'(in_ready4), 64'(1));
        check("rst_out", 64'({err4, out4}), 64'(0));
        #1 reset = 1'b0;

        // Single word through, then back to empty
        selector = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        check("dir_out", 64'(out4), 64'h33333333);
        check("dir_err", 64'(err4), 64'(0));
        in_valid = 1'b0;
        cycle();
        check("dir_empty", 64'(out_valid4), 64'(0));

        // Fill to FULL with downstream stalled, then drain
        out_ready = 1'b0; in_valid = 1'b1; selector = 2'd0;
        cycle();
        selector = 2'd3;
        cycle();
        in_valid = 1'b0;
        check("full_ready", 64'(in_ready4), 64'(0));
        check("full_out", 64'(out4), 64'h11111111);
        cycle();
        cycle();
        out_ready = 1'b1;
        cycle();
        check("drain_out", 64'(out4), 64'h44444444);
        check("drain_ready", 64'(in_ready4), 64'(1));
        cycle();

        // Back-to-back streaming, no bubbles
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            selector = 2'(i);
            cycle();
            check("stream_out", 64'(out4), 64'(32'h11111111 * (i % 4 + 1)));
            check("stream_ready", 64'(in_ready4), 64'(1));
        end

        // Out-of-range selector on the N=3 instance
        selector = 2'd3;
        cycle();
        check("oor_out", 64'(out3), 64'(0));
        check("oor_err", 64'(err3), 64'(1));
        check("oor_valid", 64'(out_valid3), 64'(1));
        check("pow2_err", 64'(err4), 64'(0));
        in_valid = 1'b0;
        cycle();

        // Reset asserted mid-cycle while FULL
        out_ready = 1'b0; in_valid = 1'b1; selector = 2'd1;
        cycle();
        cycle();
        #2 reset = 1'b1;
        #1;
        check("mrst_valid", 64'(out_valid4), 64'(0));
        check("mrst_ready", 64'(in_ready4), 64'(1));
        check("mrst_out", 64'({err4, out4}), 64'(0));
        check("mrst_valid3", 64'(out_valid3), 64'(0));
        q4.delete();
        q3.delete();
        in_valid = 1'b0; out_ready = 1'b1;
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("no_stale", 64'(out_valid4), 64'(0));
        end

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            data_in   = {$urandom, $urandom, $urandom, $urandom};
            selector  = 2'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_pipe.md
MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 Parameter WIDTH, default 32: data width of each input channel and of the output.
REQ-002 Parameter N, default 4: number of input channels; legal range 2..16.
REQ-003 Derived local SEL_W = max(1, ceil(log2(N))); not overridable.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  N*WIDTH  concatenated channels; channel k = data_in[k*WIDTH +: WIDTH].
REQ-007 selector  input  SEL_W  channel index; sampled together with data_in on accept.
REQ-008 in_valid  input  1  upstream offers data_in/selector this cycle.
REQ-009 in_ready  output  1  block can accept this cycle.
REQ-010 out  output  WIDTH  selected word at head of block.
REQ-011 out_sel_err  output  1  head word came from an out-of-range selector.
REQ-012 out_valid  output  1  out/out_sel_err hold a valid word.
REQ-013 out_ready  input  1  downstream accepts head word this cycle.

Function
REQ-014 Accept event = in_valid & in_ready at a rising edge; drain event = out_valid & out_ready at a rising edge.
REQ-015 On accept, block SHALL capture channel[selector] when selector < N, else all-zero word with error bit 1.
REQ-016 Storage SHALL be two entries: main (drives out/out_sel_err) and skid; state EMPTY, ONE or FULL.
REQ-017 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL; driven from a register only, no combinational path from out_ready.
REQ-018 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY; registered.
REQ-019 Latency SHALL be exactly one cycle: word accepted at edge t appears on out with out_valid=1 after edge t when main was empty or drained at t.
REQ-020 EMPTY: accept -> ONE, word into main; no accept -> stay.
REQ-021 ONE, accept and drain same edge -> stay ONE, new word into main.
REQ-022 ONE, accept without drain -> FULL, new word into skid, main unchanged.
REQ-023 ONE, drain without accept -> EMPTY.
REQ-024 FULL, drain -> ONE, skid moves to main; no accept possible (in_ready=0).
REQ-025 FULL, no drain -> stay, main and skid unchanged.
REQ-026 Words SHALL leave in accept order; no loss, no duplication.
REQ-027 While out_valid=1 and out_ready=0, out and out_sel_err SHALL not change.
REQ-028 Sustained throughput SHALL be one word per cycle with in_valid and out_ready held high.
REQ-029 data_in/selector changes without accept SHALL not affect out.
REQ-030 When N is a power of two, out_sel_err SHALL never assert.

Reset
REQ-031 reset high SHALL immediately (asynchronously) force state EMPTY, out_valid=0, in_ready=1, out=0, out_sel_err=0.
REQ-032 Words held at reset assertion SHALL be discarded; none emitted after release.
REQ-033 First accept possible at first rising edge with reset low.

Verification
REQ-034 WIDTH=32,N=4: channels {0x11111111,0x22222222,0x33333333,0x44444444}, selector=2, in_valid 1 cycle, out_ready=1 -> next cycle out=0x33333333, out_valid=1, out_sel_err=0; then EMPTY.
REQ-035 out_ready=0, accept selectors 0 then 3 -> after 2 edges in_ready=0, out=0x11111111 stable; raise out_ready -> out 0x11111111 then 0x44444444, in_ready back to 1.
REQ-036 in_valid=1, out_ready=1, selector stepping 0,1,2,3 every cycle -> out follows 0x11111111..0x44444444 one cycle later, no bubble, state stays ONE.
REQ-037 N=3, selector=3 accepted -> out=0x00000000, out_sel_err=1, out_valid=1.
REQ-038 FULL state, assert reset mid-cycle -> out_valid=0, in_ready=1, out=0 before next edge; after release no stale word emitted.
REQ-039 Random in_valid/out_ready over 10000 cycles with scoreboard -> order preserved, no loss or duplication, REQ-027 holds every stall cycle.
